// File: rtl/set_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : set_compare_unit
// Description : Two-stage valid/ready set-on-compare unit (SLT/SLTU/SEQ/SNE/
//               SGE/SGEU). Optional saturating true-result counter is enabled
//               by defining SET_COMPARE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module set_compare_unit #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     rs,
  input  logic [WIDTH-1:0]     rt,
  input  logic [IMM_WIDTH-1:0] immediate,
  input  logic                 use_imm,
  input  logic [2:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 mode_err
`ifdef SET_COMPARE_STATS_EN
  ,
  output logic [15:0]          true_count
`endif
);

  localparam logic [2:0] c_mode_slt  = 3'b000;
  localparam logic [2:0] c_mode_sltu = 3'b001;
  localparam logic [2:0] c_mode_seq  = 3'b010;
  localparam logic [2:0] c_mode_sne  = 3'b011;
  localparam logic [2:0] c_mode_sge  = 3'b100;
  localparam logic [2:0] c_mode_sgeu = 3'b101;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_mode;
  logic             r_s2_valid;
  logic             r_res;
  logic             r_mode_err;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_lt_s;
  logic             w_lt_u;
  logic             w_eq;
  logic             w_bit;
  logic             w_err;

  // The immediate is sign-extended even for the unsigned compare modes.
  generate
    if (IMM_WIDTH < WIDTH) begin : g_imm_sext
      assign w_imm_ext = {{(WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate};
    end else begin : g_imm_full
      assign w_imm_ext = immediate;
    end
  endgenerate

  assign w_b_sel  = use_imm ? w_imm_ext : rt;

  // in_ready is combinational from out_ready so a full pipe can drain and refill together.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !reset;
  assign w_accept = in_valid && in_ready;

  assign w_lt_s = $signed(r_s1_a) < $signed(r_s1_b);
  assign w_lt_u = r_s1_a < r_s1_b;
  assign w_eq   = r_s1_a == r_s1_b;

  always_comb begin
    w_bit = 1'b0;
    w_err = 1'b0;
    case (r_s1_mode)
      c_mode_slt:  w_bit = w_lt_s;
      c_mode_sltu: w_bit = w_lt_u;
      c_mode_seq:  w_bit = w_eq;
      c_mode_sne:  w_bit = !w_eq;
      c_mode_sge:  w_bit = !w_lt_s;
      c_mode_sgeu: w_bit = !w_lt_u;
      default:     w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s2_valid <= 1'b0;
      r_res      <= 1'b0;
      r_mode_err <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_a    <= rs;
          r_s1_b    <= w_b_sel;
          r_s1_mode <= mode;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_res      <= w_bit;
          r_mode_err <= w_err;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = {{(WIDTH-1){1'b0}}, r_res};
  assign mode_err  = r_mode_err;

`ifdef SET_COMPARE_STATS_EN
  logic [15:0] r_true_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_true_count <= '0;
    end else if (r_s2_valid && out_ready && r_res && (r_true_count != 16'hFFFF)) begin
      r_true_count <= r_true_count + 16'd1;
    end
  end

  assign true_count = r_true_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_compare_unit
// Description : Scoreboard bench for set_compare_unit (WIDTH=16, IMM_WIDTH=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_compare_unit;

  localparam int c_w   = 16;
  localparam int c_iw  = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [c_w-1:0]  rs;
  logic [c_w-1:0]  rt;
  logic [c_iw-1:0] immediate;
  logic            use_imm;
  logic [2:0]      mode;
  logic            out_valid;
  logic            out_ready;
  logic [c_w-1:0]  result;
  logic            mode_err;
`ifdef SET_COMPARE_STATS_EN
  logic [15:0]     true_count;
  int              exp_tc = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [c_w:0] sb[$];

  set_compare_unit #(.WIDTH(c_w), .IMM_WIDTH(c_iw)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .rt        (rt),
    .immediate (immediate),
    .use_imm   (use_imm),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .mode_err  (mode_err)
`ifdef SET_COMPARE_STATS_EN
    ,
    .true_count(true_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {mode_err, result} from the mode table using plain integer arithmetic.
  function automatic logic [c_w:0] model(longint a, longint b, longint imm, bit ui, int m);
    longint bv, sa, sbv, full;
    bit r;
    full = longint'(1) << c_w;
    if (ui) begin
      bv = imm;
      if (bv >= (longint'(1) << (c_iw - 1))) bv -= (longint'(1) << c_iw);
      if (bv < 0) bv += full;
    end else begin
      bv = b;
    end
    sa  = (a  >= full / 2) ? a  - full : a;
    sbv = (bv >= full / 2) ? bv - full : bv;
    case (m)
      0: r = (sa < sbv);
      1: r = (a < bv);
      2: r = (a == bv);
      3: r = (a != bv);
      4: r = (sa >= sbv);
      5: r = (a >= bv);
      default: return {1'b1, {c_w{1'b0}}};
    endcase
    return {1'b0, {(c_w-1){1'b0}}, r};
  endfunction

  function automatic logic [c_w-1:0] rnd_val();
    case ($urandom % 6)
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Presents one request from the current negedge; returns on the negedge after acceptance.
  task automatic send(input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                      input logic [c_iw-1:0] imm, input bit ui, input logic [2:0] m);
    int waited = 0;
    in_valid = 1'b1; rs = a; rt = b; immediate = imm; use_imm = ui; mode = m;
    #1;
    while (!in_ready) begin
      @(negedge clk); #1;
      waited++;
      if (waited > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(model(a, b, imm, ui, m));
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops on each output transfer, and checks holding while stalled.
  initial begin
    logic         prev_stall;
    logic [c_w:0] prev_out;
    logic [c_w:0] exp;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk); #2;
      if (prev_stall && out_valid)
        check("stall_hold", {15'd0, mode_err, result}, {15'd0, prev_out});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("result", {15'd0, mode_err, result}, {15'd0, exp});
`ifdef SET_COMPARE_STATS_EN
          check("true_count", {16'd0, true_count}, exp_tc);
          if (exp[0] && exp_tc < 32'hFFFF) exp_tc++;
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {mode_err, result};
    end
  end

  initial begin
    int got;
    reset = 1'b1; in_valid = 1'b1; rs = '0; rt = '0; immediate = '0;
    use_imm = 1'b0; mode = '0; out_ready = 1'b1;

    // Reset state, with a request offered that must not be taken.
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_result", {16'd0, result}, 0);
    check("rst_mode_err", {31'd0, mode_err}, 0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);

    // Signed boundary and two-cycle latency.
    send(16'h8000, 16'h7FFF, 6'h00, 1'b0, 3'b000);
    in_valid = 1'b0;
    #3 check("latency_c1", {31'd0, out_valid}, 0);
    @(negedge clk);
    #3 check("latency_c2", {31'd0, out_valid}, 1);
    idle_cycles(2);

    // Immediate sign extension in unsigned and signed modes.
    send(16'h0005, 16'h0000, 6'h3F, 1'b1, 3'b001);
    send(16'h0005, 16'h0000, 6'h3F, 1'b1, 3'b000);
    // Back-to-back.
    send(16'h1234, 16'h1234, 6'h00, 1'b0, 3'b010);
    send(16'h1234, 16'h1234, 6'h00, 1'b0, 3'b011);
    send(16'h0000, 16'h0001, 6'h00, 1'b0, 3'b101);
    send(16'h7FFF, 16'h8000, 6'h00, 1'b0, 3'b100);
    send(16'h0001, 16'h0002, 6'h00, 1'b0, 3'b110);
    send(16'hFFFF, 16'hFFFF, 6'h00, 1'b0, 3'b111);
    idle_cycles(4);

    // Stall: two accepted, third refused until release.
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 6'h00, 1'b0, 3'b000);
    send(16'h0003, 16'h0003, 6'h00, 1'b0, 3'b010);
    in_valid = 1'b1; rs = 16'h0009; rt = 16'h0001; use_imm = 1'b0; mode = 3'b101;
    repeat (3) begin
      #1 check("stall_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(16'h0009, 16'h0001, 6'h00, 1'b0, 3'b101);
    idle_cycles(4);

    // Reset with two requests in flight discards both.
    out_ready = 1'b0;
    send(16'h0000, 16'h0001, 6'h00, 1'b0, 3'b000);
    send(16'h0000, 16'h0000, 6'h00, 1'b0, 3'b010);
    in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    #1 check("rst_mid_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
`ifdef SET_COMPARE_STATS_EN
    exp_tc = 0;
`endif
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 0);
    check("rst_mid_in_ready_after", {31'd0, in_ready}, 1);
    @(negedge clk);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      rs = rnd_val(); rt = rnd_val();
      immediate = 6'($urandom); use_imm = 1'($urandom); mode = 3'($urandom);
      #1;
      if (in_valid && in_ready) sb.push_back(model(rs, rt, immediate, use_imm, mode));
      @(negedge clk);
    end

`ifdef SET_COMPARE_STATS_EN
    // Saturation of the true-result counter.
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 70000 && got < 65536; i++) begin
      in_valid = 1'b1; rs = 16'h0000; rt = 16'h0000; use_imm = 1'b0; mode = 3'b010;
      #1;
      if (in_ready) begin
        sb.push_back(model(0, 0, 0, 1'b0, 2));
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #3 check("tc_saturated", {16'd0, true_count}, 32'hFFFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_tc = 0;
    #3 check("tc_reset", {16'd0, true_count}, 0);
`endif

    // Drain.
    out_ready = 1'b1;
    in_valid  = 1'b0;
    got = 0;
    while (sb.size() != 0 && got < 20) begin
      @(negedge clk);
      got++;
    end
    check("drain_empty", sb.size(), 0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
